// File: rtl/dct_mem_pkg.sv
// Shared constants and FSM state type for the DCT memory sequencer.
package dct_mem_pkg;

   localparam int ADDR_W        = 14;
   localparam int RA_W          = 10;
   localparam int CA_W          = 4;
   localparam int FRAME_WORDS   = 16384;
   localparam int DRAIN_TIMEOUT = 64;

   // Write counter must be able to hold FRAME_WORDS itself.
   localparam int CNT_W = 15;
   // Drain timer must be able to hold DRAIN_TIMEOUT itself.
   localparam int TMR_W = 7;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FRAME_WORDS);
   localparam logic [TMR_W-1:0]  TMR_LIMIT = TMR_W'(DRAIN_TIMEOUT);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(DRAIN_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/sram_addr_gen.sv
// 14-bit SRAM address counter with synchronous clear and increment;
// the address leaves the block already split into row and column.
module sram_addr_gen
   import dct_mem_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            incr,
   output logic [RA_W-1:0] ra,
   output logic [CA_W-1:0] ca
);

   logic [ADDR_W-1:0] addr;

   // Address register: clear wins over increment.
   always_ff @(posedge clk) begin
      if (!reset) begin
         addr <= '0;
      end else if (clear) begin
         addr <= '0;
      end else if (incr) begin
         addr <= addr + 1'b1;
      end
   end

   assign ra = addr[ADDR_W-1:CA_W];
   assign ca = addr[CA_W-1:0];

endmodule

// File: rtl/dct_mem_sequencer.sv
// Frame sequencer between an input SRAM, a DCT core and an output SRAM.
// One start request reads the whole 16384-word input frame in order,
// toggles dct_flag at every 16-word block boundary and writes each DCT
// output word to the next output address, then waits (with a timeout)
// for the DCT pipeline to drain.
module dct_mem_sequencer
   import dct_mem_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            timeout_err,
   output logic            in_nce,
   output logic            in_nwrt,
   output logic [RA_W-1:0] in_ra,
   output logic [CA_W-1:0] in_ca,
   output logic            dct_flag,
   input  logic            dct_oen3,
   input  logic            dct_oen4,
   output logic            out_nce,
   output logic            out_nwrt,
   output logic [RA_W-1:0] out_ra,
   output logic [CA_W-1:0] out_ca,
   output state_t          fsm_state
);

   state_t            state;
   state_t            next_state;
   logic              accept;
   logic              rd_last;
   logic              rd_incr;
   logic              wr_en;
   logic              wr_full;
   logic              drain_expire;
   logic [CNT_W-1:0]  wr_cnt;
   logic [TMR_W-1:0]  drain_tmr;

   // Write contract with the DCT core: a write happens in exactly the
   // cycles where either output strobe is high while the frame is active
   // (READ or DRAIN) and fewer than FRAME_WORDS words have been written.
   // There is no back-pressure; the output SRAM accepts every such write,
   // and the write address advances on the edge that ends the write cycle.
   assign accept       = (state == ST_IDLE) && start;
   assign rd_last      = (state == ST_READ) && ({in_ra, in_ca} == LAST_ADDR);
   assign rd_incr      = (state == ST_READ) && !rd_last;
   assign wr_full      = (wr_cnt == FULL_CNT);
   assign wr_en        = ((state == ST_READ) || (state == ST_DRAIN))
                         && (dct_oen3 || dct_oen4) && !wr_full;
   assign drain_expire = (state == ST_DRAIN) && !wr_en && !wr_full
                         && (drain_tmr == TMR_LAST);

   assign in_nwrt   = 1'b1;
   assign out_nwrt  = ~wr_en;
   assign fsm_state = state;

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and per-state control outputs.
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      in_nce     = 1'b1;
      out_nce    = 1'b1;
      case (state)
         ST_IDLE: begin
            if (start) begin
               next_state = ST_READ;
            end
         end
         ST_READ: begin
            busy    = 1'b1;
            in_nce  = 1'b0;
            out_nce = 1'b0;
            if (rd_last) begin
               next_state = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            busy    = 1'b1;
            out_nce = 1'b0;
            if (wr_full || drain_expire) begin
               next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Write count, drain timer and sticky timeout flag; all restart on an
   // accepted start. The timer saturates so it never wraps back under the
   // limit while the state machine is leaving DRAIN.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_cnt      <= '0;
         drain_tmr   <= '0;
         timeout_err <= 1'b0;
      end else if (accept) begin
         wr_cnt      <= '0;
         drain_tmr   <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_cnt <= wr_cnt + 1'b1;
         end
         if (state == ST_DRAIN) begin
            if (wr_en) begin
               drain_tmr <= '0;
            end else if (drain_tmr != TMR_LIMIT) begin
               drain_tmr <= drain_tmr + 1'b1;
            end
         end
         if (drain_expire) begin
            timeout_err <= 1'b1;
         end
      end
   end

   // Block-boundary toggle. The register updates on the edge that ends the
   // issue cycle of a CA = 0 address, so the new level appears together
   // with that word's read data one cycle later. Cleared in DONE so the
   // idle level is always 0.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dct_flag <= 1'b0;
      end else if ((state == ST_READ) && (in_ca == '0)) begin
         dct_flag <= ~dct_flag;
      end else if (state == ST_DONE) begin
         dct_flag <= 1'b0;
      end
   end

   sram_addr_gen u_rd_addr (
      .clk   (clk),
      .reset (reset),
      .clear (accept),
      .incr  (rd_incr),
      .ra    (in_ra),
      .ca    (in_ca)
   );

   sram_addr_gen u_wr_addr (
      .clk   (clk),
      .reset (reset),
      .clear (accept),
      .incr  (wr_en),
      .ra    (out_ra),
      .ca    (out_ca)
   );

endmodule

// File: tb/tb_dct_mem_sequencer.sv
// Self-checking bench for dct_mem_sequencer. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge. "Cycle c" is the
// period starting at the c-th rising edge after start is driven.
module tb_dct_mem_sequencer;
  import dct_mem_pkg::*;

  logic       clk;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic       in_nce;
  logic       in_nwrt;
  logic [9:0] in_ra;
  logic [3:0] in_ca;
  logic       dct_flag;
  logic       dct_oen3;
  logic       dct_oen4;
  logic       out_nce;
  logic       out_nwrt;
  logic [9:0] out_ra;
  logic [3:0] out_ca;
  state_t     fsm_state;

  logic [7:0] ctl;
  assign ctl = {busy, done, timeout_err, in_nce, in_nwrt, out_nce, out_nwrt, dct_flag};
  localparam logic [7:0] CTL_RESET = 8'b0001_1110;

  int vectors = 0;
  int miscompares = 0;

  // Reference-model state for a frame driven by the DCT model
  int         pending;
  int         writes;
  int         last_wr;
  int         done_cycle;
  int         done_cycles;
  logic       err_at_done;
  int         written[16384];
  logic [13:0] exp_q[$];

  dct_mem_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .timeout_err(timeout_err), .in_nce(in_nce), .in_nwrt(in_nwrt),
    .in_ra(in_ra), .in_ca(in_ca), .dct_flag(dct_flag),
    .dct_oen3(dct_oen3), .dct_oen4(dct_oen4), .out_nce(out_nce),
    .out_nwrt(out_nwrt), .out_ra(out_ra), .out_ca(out_ca),
    .fsm_state(fsm_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    dct_oen3 = 1'b0;
    dct_oen4 = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // DCT model: every word read from the input SRAM becomes one pending
  // output word; a pending word is written out on a random 3-in-4 cycle,
  // up to quota words. Optionally strobes once more after 16384 writes.
  task automatic run_dct_frame(input int quota, input bit poke_full);
    bit prev_issue = 1'b0;
    bit strobe;
    bit poked = 1'b0;
    bit finished = 1'b0;
    logic [13:0] exp_addr;
    pending = 0; writes = 0; last_wr = -1;
    done_cycle = -1; done_cycles = 0; err_at_done = 1'bx;
    exp_q.delete();
    foreach (written[i]) written[i] = 0;
    start = 1'b1;
    for (int c = 0; c < 40000 && !finished; c++) begin
      if (c == 1) start = 1'b0;
      if (prev_issue) pending++;
      strobe = (pending > 0) && (writes < quota) && ($urandom_range(0, 3) != 0);
      if (strobe) exp_q.push_back(14'(writes));
      dct_oen3 = strobe || (poke_full && writes == 16384 && !poked);
      if (poke_full && writes == 16384) poked = 1'b1;
      @(negedge clk);
      vectors++;
      if (out_nwrt !== (strobe ? 1'b0 : 1'b1)) begin
        miscompares++;
        $display("FAIL frame_out_nwrt cycle %0d: got %b expected %b", c, out_nwrt, !strobe);
      end
      if (strobe) begin
        exp_addr = exp_q.pop_front();
        vectors++;
        if ({out_ra, out_ca} !== exp_addr) begin
          miscompares++;
          $display("FAIL frame_wr_addr cycle %0d: got %0d expected %0d", c, {out_ra, out_ca}, exp_addr);
        end
        written[{out_ra, out_ca}]++;
        writes++;
        pending--;
        last_wr = c;
      end
      prev_issue = (in_nce === 1'b0);
      if (done === 1'b1) begin
        if (done_cycles == 0) begin
          done_cycle = c;
          err_at_done = timeout_err;
        end
        done_cycles++;
      end
      if (done_cycle >= 0 && c >= done_cycle + 3) finished = 1'b1;
      tick();
    end
    dct_oen3 = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b1;
    dct_oen3 = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    vectors++;
    if (ctl !== CTL_RESET) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_RESET);
    end
    vectors++;
    if ({fsm_state, in_ra, in_ca, out_ra, out_ca} !== {ST_IDLE, 28'd0}) begin
      miscompares++;
      $display("FAIL reset_state_addr: got %0d/%0d/%0d expected 0/0/0", fsm_state, {in_ra, in_ca}, {out_ra, out_ca});
    end
    start = 1'b0;
    dct_oen3 = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== CTL_RESET) begin
      miscompares++;
      $display("FAIL reset_release_ctl: got %b expected %b", ctl, CTL_RESET);
    end
    tick();
  endtask

  task automatic test_read_sequence();
    logic exp_flag;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      // addresses 0..c-2 have been issued before cycle c; each CA=0 one toggles the flag
      exp_flag = (c < 2) ? 1'b0 : ((((c - 2) / 16) + 1) % 2 == 1);
      vectors++;
      if ({busy, in_nce, out_nce} !== 3'b100) begin
        miscompares++;
        $display("FAIL read_enables cycle %0d: got %b expected 100", c, {busy, in_nce, out_nce});
      end
      vectors++;
      if ({in_ra, in_ca} !== 14'(c - 1)) begin
        miscompares++;
        $display("FAIL read_addr cycle %0d: got %0d/%0d expected %0d", c, in_ra, in_ca, c - 1);
      end
      vectors++;
      if (dct_flag !== exp_flag) begin
        miscompares++;
        $display("FAIL read_flag cycle %0d: got %b expected %b", c, dct_flag, exp_flag);
      end
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== CTL_RESET || fsm_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL read_abort: got %b/%0d expected %b/0", ctl, fsm_state, CTL_RESET);
    end
    tick();
  endtask

  task automatic test_full_frame();
    int bad = 0;
    run_dct_frame(16384, 1'b1);
    foreach (written[i]) if (written[i] != 1) bad++;
    vectors++;
    if (done_cycle < 0) begin
      miscompares++;
      $display("FAIL full_done_seen: got none expected one pulse within budget");
    end
    vectors++;
    if (writes != 16384) begin
      miscompares++;
      $display("FAIL full_writes: got %0d expected 16384", writes);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL full_once: got %0d addresses not written once expected 0", bad);
    end
    vectors++;
    if (done_cycles != 1) begin
      miscompares++;
      $display("FAIL full_done_len: got %0d expected 1", done_cycles);
    end
    vectors++;
    if (err_at_done !== 1'b0) begin
      miscompares++;
      $display("FAIL full_timeout_err: got %b expected 0", err_at_done);
    end
    @(negedge clk);
    // 16384 increments of a 14-bit address wrap to 0; the extra strobe is ignored
    vectors++;
    if ({out_ra, out_ca} !== 14'd0 || fsm_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL full_end_addr: got %0d/%0d expected 0/0", {out_ra, out_ca}, fsm_state);
    end
    tick();
  endtask

  task automatic test_timeout();
    run_dct_frame(16000, 1'b0);
    vectors++;
    if (done_cycle < 0) begin
      miscompares++;
      $display("FAIL to_done_seen: got none expected one pulse within budget");
    end
    vectors++;
    if (writes != 16000) begin
      miscompares++;
      $display("FAIL to_writes: got %0d expected 16000", writes);
    end
    // last write commits at the end of cycle W; done rises 64 edges later,
    // which is the start of cycle W+65
    vectors++;
    if (done_cycle - last_wr != 65) begin
      miscompares++;
      $display("FAIL to_latency: got %0d expected 65", done_cycle - last_wr);
    end
    vectors++;
    if (err_at_done !== 1'b1) begin
      miscompares++;
      $display("FAIL to_err_at_done: got %b expected 1", err_at_done);
    end
    vectors++;
    if (done_cycles != 1) begin
      miscompares++;
      $display("FAIL to_done_len: got %0d expected 1", done_cycles);
    end
    @(negedge clk);
    vectors++;
    if ({out_ra, out_ca, timeout_err} !== {10'd1000, 4'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL to_retained: got %0d/%0d err %b expected 1000/0 err 1", out_ra, out_ca, timeout_err);
    end
    tick();
  endtask

  task automatic test_mid_frame_reset();
    int guard = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL mr_err_cleared_by_start: got %b expected 0", timeout_err);
    end
    while (guard < 6000 && {in_ra, in_ca} !== 14'd4999) begin
      tick();
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (guard >= 6000) begin
      miscompares++;
      $display("FAIL mr_reach_4999: got %0d expected 4999 within budget", {in_ra, in_ca});
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({in_ra, in_ca} !== 14'd5000) begin
      miscompares++;
      $display("FAIL mr_addr_5000: got %0d expected 5000", {in_ra, in_ca});
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== CTL_RESET || fsm_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL mr_reset_ctl: got %b/%0d expected %b/0", ctl, fsm_state, CTL_RESET);
    end
    vectors++;
    if ({in_ra, in_ca, out_ra, out_ca} !== 28'd0) begin
      miscompares++;
      $display("FAIL mr_reset_addr: got %0d/%0d expected 0/0", {in_ra, in_ca}, {out_ra, out_ca});
    end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({in_nce, in_ra, in_ca} !== 15'd0) begin
      miscompares++;
      $display("FAIL mr_restart: got nce %b addr %0d expected nce 0 addr 0", in_nce, {in_ra, in_ca});
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_ignored_inputs();
    int guard = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    start = 1'b1;
    @(negedge clk);
    vectors++;
    if ({in_ra, in_ca} !== 14'd9) begin
      miscompares++;
      $display("FAIL ig_addr_before: got %0d expected 9", {in_ra, in_ca});
    end
    tick();
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({in_ra, in_ca} !== 14'd10 || fsm_state !== ST_READ) begin
      miscompares++;
      $display("FAIL ig_start_in_read: got %0d/%0d expected 10/1", {in_ra, in_ca}, fsm_state);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      dct_oen3 = 1'b1;
      dct_oen4 = 1'b1;
      @(negedge clk);
      vectors++;
      if ({out_nwrt, out_ra, out_ca} !== {1'b0, 14'(i)}) begin
        miscompares++;
        $display("FAIL dual_strobe %0d: got nwrt %b addr %0d expected nwrt 0 addr %0d", i, out_nwrt, {out_ra, out_ca}, i);
      end
    end
    tick();
    dct_oen3 = 1'b0;
    dct_oen4 = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_nwrt, out_ra, out_ca} !== {1'b1, 14'd3}) begin
      miscompares++;
      $display("FAIL dual_after: got nwrt %b addr %0d expected nwrt 1 addr 3", out_nwrt, {out_ra, out_ca});
    end
    while (guard < 20000 && done !== 1'b1) begin
      tick();
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (done !== 1'b1 || timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL ig_timeout_done: got done %b err %b expected 1 1", done, timeout_err);
    end
    tick();
    dct_oen4 = 1'b1;
    @(negedge clk);
    vectors++;
    if (fsm_state !== ST_IDLE || out_nwrt !== 1'b1) begin
      miscompares++;
      $display("FAIL ig_idle_strobe: got state %0d nwrt %b expected 0 1", fsm_state, out_nwrt);
    end
    tick();
    dct_oen4 = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_ra, out_ca} !== 14'd3) begin
      miscompares++;
      $display("FAIL ig_idle_addr: got %0d expected 3", {out_ra, out_ca});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_read_sequence();
    test_full_frame();
    test_timeout();
    test_mid_frame_reset();
    test_ignored_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
